// File: rtl/bank_isu_pkg.sv
// Shared types for the bank issue queue:
// SRAM-controller opcodes, request opcode bits, entry payload.
package bank_isu_pkg;

  localparam logic [1:0] SC_OP_WRITE   = 2'd0;
  localparam logic [1:0] SC_OP_READ    = 2'd1;
  localparam logic [1:0] SC_OP_READ_LF = 2'd2;
  localparam logic [1:0] SC_OP_WB      = 2'd3;

  localparam int REQ_OP_WRITE = 0;
  localparam int REQ_OP_EVICT = 1;

  // Entry field widths; the top-level defaults match these.
  localparam int E_CH_W   = 2;
  localparam int E_ROB_W  = 3;
  localparam int E_SWO_W  = 7;
  localparam int E_WBUF_W = 8;

  typedef struct packed {
    logic [E_CH_W-1:0]   ch;
    logic [E_ROB_W-1:0]  rob;
    logic [E_SWO_W-1:0]  swo;
    logic [E_WBUF_W-1:0] wbuf;
    logic [3:0]          state;
    logic                is_write;
    logic                need_lf;
    logic                evict;
  } entry_t;

endpackage

// File: rtl/bank_isu_age_arb.sv
// Rotating-priority find-first: oldest set request from bptr_i.
// Ports: req_i (per slot), bptr_i -> select_ptr_o, any_valid_o.
module bank_isu_age_arb #(
  parameter int PTR_WIDTH = 3
) (
  input  logic [2**PTR_WIDTH-1:0] req_i,
  input  logic [PTR_WIDTH-1:0]    bptr_i,
  output logic [PTR_WIDTH-1:0]    select_ptr_o,
  output logic                    any_valid_o
);

  localparam int DEPTH = 2**PTR_WIDTH;

  logic [PTR_WIDTH-1:0] idx;

  // Walk from youngest to oldest so the oldest hit wins.
  always_comb begin
    select_ptr_o = bptr_i;
    any_valid_o  = 1'b0;
    idx          = bptr_i;
    for (int k = DEPTH-1; k >= 0; k--) begin
      idx = bptr_i + PTR_WIDTH'(k);
      if (req_i[idx]) begin
        select_ptr_o = idx;
        any_valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_isu_iq_gen.sv
// Issue queue between bank hit/tag unit and SRAM controller.
// Ports: req_* enqueue, biu_isu_r* linefill wake, channel_pop_i
// credit return, iq_sc_* issue handshake, iq_count_o occupancy.
module bank_isu_iq_gen
  import bank_isu_pkg::*;
#(
  parameter int PTR_WIDTH   = 3,
  parameter int CH_NUM      = 4,
  parameter int CH_W        = 2,
  parameter int CREDIT_W    = 3,
  parameter int CREDIT_INIT = 4,
  parameter int SWO_W       = 7,
  parameter int ROB_W       = 3,
  parameter int WBUF_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_allowIn_o,
  input  logic [1:0]            req_opcode_i,
  input  logic                  req_need_linefill_i,
  input  logic                  req_cacheline_inflight_i,
  input  logic [CH_W-1:0]       req_ch_id_i,
  input  logic [ROB_W-1:0]      req_rob_id_i,
  input  logic [SWO_W-1:0]      req_set_way_offset_i,
  input  logic [WBUF_W-1:0]     req_wbuffer_id_i,
  input  logic [3:0]            req_line_state_i,
  input  logic                  biu_isu_rvalid_i,
  input  logic [SWO_W-2:0]      biu_isu_rid_i,
  input  logic [CH_NUM-1:0]     channel_pop_i,
  output logic                  iq_sc_valid_o,
  input  logic                  iq_sc_ready_i,
  output logic [1:0]            iq_sc_opcode_o,
  output logic [CH_W-1:0]       iq_sc_channel_id_o,
  output logic [ROB_W-1:0]      iq_sc_rob_id_o,
  output logic [SWO_W-1:0]      iq_sc_set_way_offset_o,
  output logic [WBUF_W-1:0]     iq_sc_wbuffer_id_o,
  output logic [3:0]            iq_sc_line_state_o,
  output logic [SWO_W-2:0]      iq_linefill_raddr_o,
  output logic [PTR_WIDTH:0]    iq_count_o
);

  localparam int DEPTH = 2**PTR_WIDTH;

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     rdy_q, rdy_d;
  entry_t               ent_q [DEPTH];
  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] bptr_q, bptr_d;
  logic [PTR_WIDTH:0]   cnt_q, cnt_d;
  logic [CREDIT_W-1:0]  cred_q [CH_NUM];
  logic [CREDIT_W-1:0]  cred_d [CH_NUM];

  logic [DEPTH-1:0]     elig;
  logic [PTR_WIDTH-1:0] sel;
  logic                 any;
  entry_t               sel_e;
  entry_t               req_e;
  logic                 enq, fire, retire, lf_hit;
  logic                 take_cred;
  logic [CH_NUM-1:0]    take;

  assign req_allowIn_o = cnt_q != (PTR_WIDTH+1)'(DEPTH);
  assign enq    = req_valid_i & req_allowIn_o;
  assign fire   = any & iq_sc_ready_i;
  assign retire = (cnt_q != '0) & ~valid_q[bptr_q];
  assign sel_e  = ent_q[sel];
  assign lf_hit = biu_isu_rvalid_i &
                  (biu_isu_rid_i == req_set_way_offset_i[SWO_W-1:1]);

  // Write-back and write phases never spend a read credit.
  assign take_cred = fire & ~sel_e.evict & ~sel_e.is_write;

  always_comb begin
    req_e          = '0;
    req_e.ch       = req_ch_id_i;
    req_e.rob      = req_rob_id_i;
    req_e.swo      = req_set_way_offset_i;
    req_e.wbuf     = req_wbuffer_id_i;
    req_e.state    = req_line_state_i;
    req_e.is_write = req_opcode_i[REQ_OP_WRITE];
    req_e.need_lf  = req_need_linefill_i;
    req_e.evict    = req_opcode_i[REQ_OP_EVICT];
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i] & (ent_q[i].evict |
                (rdy_q[i] & (ent_q[i].is_write |
                 (cred_q[ent_q[i].ch] != '0))));
    end
  end

  bank_isu_age_arb #(
    .PTR_WIDTH (PTR_WIDTH)
  ) u_arb (
    .req_i        (elig),
    .bptr_i       (bptr_q),
    .select_ptr_o (sel),
    .any_valid_o  (any)
  );

  always_comb begin
    valid_d = valid_q;
    rdy_d   = rdy_q;
    wptr_d  = wptr_q;
    bptr_d  = bptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && biu_isu_rvalid_i &&
          biu_isu_rid_i == ent_q[i].swo[SWO_W-1:1])
        rdy_d[i] = 1'b1;
    end
    // An evict entry stays queued for its linefill read.
    if (fire && !sel_e.evict)
      valid_d[sel] = 1'b0;
    if (retire)
      bptr_d = bptr_q + 1'b1;
    if (enq) begin
      valid_d[wptr_q] = 1'b1;
      rdy_d[wptr_q]   = ~(req_need_linefill_i |
                          req_cacheline_inflight_i) | lf_hit;
      wptr_d          = wptr_q + 1'b1;
    end
    cnt_d = cnt_q + (PTR_WIDTH+1)'(enq) - (PTR_WIDTH+1)'(retire);
  end

  always_comb begin
    take = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      take[c]   = take_cred & (sel_e.ch == CH_W'(c));
      cred_d[c] = cred_q[c];
      if (channel_pop_i[c] && !take[c]) begin
        if (cred_q[c] != CREDIT_W'(CREDIT_INIT))
          cred_d[c] = cred_q[c] + 1'b1;
      end else if (take[c] && !channel_pop_i[c]) begin
        cred_d[c] = cred_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      rdy_q   <= '0;
      wptr_q  <= '0;
      bptr_q  <= '0;
      cnt_q   <= '0;
      for (int c = 0; c < CH_NUM; c++)
        cred_q[c] <= CREDIT_W'(CREDIT_INIT);
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      wptr_q  <= wptr_d;
      bptr_q  <= bptr_d;
      cnt_q   <= cnt_d;
      for (int c = 0; c < CH_NUM; c++)
        cred_q[c] <= cred_d[c];
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (enq)
      ent_q[wptr_q] <= req_e;
    if (fire && sel_e.evict)
      ent_q[sel].evict <= 1'b0;
  end

  always_comb begin
    if (sel_e.evict)
      iq_sc_opcode_o = SC_OP_WB;
    else if (sel_e.is_write)
      iq_sc_opcode_o = SC_OP_WRITE;
    else if (sel_e.need_lf)
      iq_sc_opcode_o = SC_OP_READ_LF;
    else
      iq_sc_opcode_o = SC_OP_READ;
  end

  assign iq_sc_valid_o          = any;
  assign iq_sc_channel_id_o     = sel_e.ch;
  assign iq_sc_rob_id_o         = sel_e.rob;
  assign iq_sc_set_way_offset_o = sel_e.swo;
  assign iq_sc_wbuffer_id_o     = sel_e.wbuf;
  assign iq_sc_line_state_o     = sel_e.state;
  assign iq_linefill_raddr_o    = sel_e.swo[SWO_W-1:1];
  assign iq_count_o             = cnt_q;

endmodule

// File: doc/bank_isu_iq_gen.md
Name: bank_isu_iq_gen

Overview:
- Parametrised issue queue between the bank hit/tag unit and the SRAM controller.
- Holds up to DEPTH requests in arrival order.
- Wakes miss/inflight entries on linefill return and gates reads on per-channel credit counters kept inside the block.
- Issues the oldest eligible entry each cycle; evict requests issue twice, first as write-back, then as linefill read.

Parameters:
- PTR_WIDTH, 3, log2 of queue depth; DEPTH = 2**PTR_WIDTH.
- CH_NUM, 4, number of response channels.
- CH_W, 2, channel id width (>= clog2(CH_NUM)).
- CREDIT_W, 3, credit counter width.
- CREDIT_INIT, 4, per-channel credits after reset (<= 2**CREDIT_W-1).
- SWO_W, 7, set/way/offset width; bit 0 is the half-line offset, [SWO_W-1:1] is the line id.
- ROB_W, 3, xbar rob id width.
- WBUF_W, 8, write-buffer id width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_allowIn_o  out  1  queue can accept (count != DEPTH)
- req_opcode_i  in  2  bit0 write, bit1 evict
- req_need_linefill_i  in  1  miss, needs linefill
- req_cacheline_inflight_i  in  1  hit on line still being filled
- req_ch_id_i  in  CH_W  response channel
- req_rob_id_i  in  ROB_W  rob id
- req_set_way_offset_i  in  SWO_W  SRAM location
- req_wbuffer_id_i  in  WBUF_W  write buffer slot
- req_line_state_i  in  4  {offset1,offset0} line state
- biu_isu_rvalid_i  in  1  linefill data arrived
- biu_isu_rid_i  in  SWO_W-1  line id of returned data
- channel_pop_i  in  CH_NUM  per-channel credit release pulse
- iq_sc_valid_o  out  1  issue valid
- iq_sc_ready_i  in  1  SRAM controller accepts
- iq_sc_opcode_o  out  2  0 write, 1 read, 2 read+linefill, 3 write-back
- iq_sc_channel_id_o  out  CH_W
- iq_sc_rob_id_o  out  ROB_W
- iq_sc_set_way_offset_o  out  SWO_W
- iq_sc_wbuffer_id_o  out  WBUF_W
- iq_sc_line_state_o  out  4
- iq_linefill_raddr_o  out  SWO_W-1  selected entry line id
- iq_count_o  out  PTR_WIDTH+1  occupancy

Behaviour:
- Reset: all entries invalid, write/bottom pointers 0, count 0, credits CREDIT_INIT.
- After reset: iq_sc_valid_o=0, req_allowIn_o=1, iq_count_o=0. Payload outputs are don't-care while iq_sc_valid_o=0.
- Enqueue when req_valid_i & req_allowIn_o, into slot wptr; wptr increments mod DEPTH. Payload registers are written only on enqueue.
- Per-entry ready (mshr) flag:
  - On enqueue, ready = ~(need_linefill | inflight).
  - The flag is also set if biu_isu_rvalid_i is high that same cycle with rid == req swo[SWO_W-1:1]. This same-cycle bypass is new behaviour and mandatory.
  - A valid entry's flag sets when rvalid & rid matches its line id. Flags never clear while the entry is valid.
- Eligibility:
  - Write-back phase (evict flag set): always eligible.
  - Write (op 0): eligible when ready.
  - Read or linefill read (op 1/2): eligible when ready and credit[ch] != 0.
- Selection: oldest eligible entry scanning circularly from the bottom pointer. iq_sc_valid_o = any eligible entry. Outputs are combinational from registered state, zero-latency issue.
- Opcode of selected entry: evict -> 3; else write -> 0; else need_linefill -> 2; else 1.
- On issue handshake (valid & ready):
  - Evict entry: clear evict flag, keep the entry valid. It re-issues later as op 2 once ready.
  - Any other entry: invalidate.
- Credits:
  - Issuing op 1/2 on channel c decrements credit[c]; channel_pop_i[c] increments it.
  - Both in the same cycle: unchanged.
  - Increment saturates at CREDIT_INIT; decrement never occurs at 0 by construction.
- Retire: if count != 0 and entry[bptr] is invalid, bptr increments and count decrements, at most one per cycle.
- Count: enqueue and retire in the same cycle leaves it unchanged. Full (count==DEPTH) deasserts allowIn even if a retire occurs that cycle (no full-bypass).
- Pointer wrap is plain modulo DEPTH; the age scan handles wptr < bptr.
- Asynchronous reset mid-operation discards all entries and restores credits immediately.

Decomposition:
- Package bank_isu_pkg holds:
  - opcode localparams: SC_OP_WRITE=0, SC_OP_READ=1, SC_OP_READ_LF=2, SC_OP_WB=3;
  - the req opcode bit positions;
  - an entry struct typedef {ch, rob, swo, wbuf, state, is_write, need_lf, evict}.
- Sub-module bank_isu_age_arb (parameter PTR_WIDTH): rotating-priority find-first from the bottom pointer; outputs select_ptr and any_valid.

Test Plan:
- Reset, enqueue one read hit (op 0b00, need_lf=0, ch=1) with ready=1 -> same cycle after enqueue, iq_sc_valid_o=1, opcode=1, ch=1; credit[1] drops 4->3; entry retires next cycle; count returns 0.
- Fill 8 entries, hold ready=0 -> allowIn=0 at count=8; then ready=1 -> one issue per cycle in age order, after wptr/bptr wrap.
- Miss (need_lf=1, swo=0x2A) -> no issue until rvalid with rid=0x15 -> next cycle opcode=2. Repeat with rvalid in the enqueue cycle -> issues the following cycle.
- Evict (op 0b10, need_lf=1) -> first issue opcode=3 with no credit used. Then rvalid for its line -> second issue opcode=2; the entry then invalidates.
- Ch 0 with 4 back-to-back read hits plus a 5th -> 5th stalls, while a younger write on ch 2 issues around it. A channel_pop_i[0] pulse -> 5th issues next cycle; a simultaneous pop and issue leaves the credit unchanged.
- Assert rst_i asynchronously with 5 entries queued -> outputs return to reset values before the next clock edge; credits read back as 4.
